// File: rtl/id_ex_imm_stage.sv
// ID/EX pipeline register: operand-B select, branch target, bubble count.
// Define IMM_ZERO_EXT_EN to add id_imm_zext (zero-extended logical imm).
module id_ex_imm_stage #(
  parameter int DW    = 32,
  parameter int RW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [DW-1:0]    id_pc_plus4,
  input  logic [DW-1:0]    id_imm_ext,
  input  logic [DW-1:0]    id_rs_data,
  input  logic [DW-1:0]    id_rt_data,
  input  logic [RW-1:0]    id_rt,
  input  logic [RW-1:0]    id_rd,
  input  logic             id_alu_src,
  input  logic             id_reg_dst,
  input  logic [3:0]       id_alu_op,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_branch,
`ifdef IMM_ZERO_EXT_EN
  input  logic             id_imm_zext,
`endif
  output logic             ex_valid,
  output logic [DW-1:0]    ex_alu_a,
  output logic [DW-1:0]    ex_alu_b,
  output logic [DW-1:0]    ex_rt_data,
  output logic [DW-1:0]    ex_imm,
  output logic [DW-1:0]    ex_br_target,
  output logic [RW-1:0]    ex_dst,
  output logic [3:0]       ex_alu_op,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_branch,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [DW-1:0] br_target;
    logic [RW-1:0] dst;
    logic [3:0]    alu_op;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          branch;
  } ex_t;

  ex_t             ex_q;
  ex_t             ex_d;
  logic [DW-1:0]   imm_sel;
  logic            bubble;
  logic            load;
  logic [CNT_W-1:0] cnt_nxt;

`ifdef IMM_ZERO_EXT_EN
  assign imm_sel = id_imm_zext
    ? {{(DW-16){1'b0}}, id_imm_ext[15:0]}
    : id_imm_ext;
`else
  assign imm_sel = id_imm_ext;
`endif

  // a squashed or empty slot both become an all-zero bubble
  assign bubble = flush | (~stall & ~id_valid);
  assign load   = ~flush & ~stall & id_valid;

  assign cnt_nxt = (&bubble_cnt)
    ? bubble_cnt
    : bubble_cnt + CNT_W'(1);

  always_comb begin
    ex_d           = '0;
    ex_d.valid     = 1'b1;
    ex_d.alu_a     = id_rs_data;
    ex_d.alu_b     = id_alu_src ? imm_sel : id_rt_data;
    ex_d.rt_data   = id_rt_data;
    ex_d.imm       = imm_sel;
    ex_d.br_target = id_pc_plus4
                   + {imm_sel[DW-3:0], 2'b00};
    ex_d.dst       = id_reg_dst ? id_rd : id_rt;
    ex_d.alu_op    = id_alu_op;
    ex_d.reg_write = id_reg_write;
    ex_d.mem_read  = id_mem_read;
    ex_d.mem_write = id_mem_write;
    ex_d.branch    = id_branch;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q       <= '0;
      bubble_cnt <= '0;
    end else if (bubble) begin
      ex_q       <= '0;
      bubble_cnt <= cnt_nxt;
    end else if (load) begin
      ex_q       <= ex_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_alu_a     = ex_q.alu_a;
  assign ex_alu_b     = ex_q.alu_b;
  assign ex_rt_data   = ex_q.rt_data;
  assign ex_imm       = ex_q.imm;
  assign ex_br_target = ex_q.br_target;
  assign ex_dst       = ex_q.dst;
  assign ex_alu_op    = ex_q.alu_op;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_branch    = ex_q.branch;

endmodule

// File: tb/tb_id_ex_imm_stage.sv
// Bench for id_ex_imm_stage: vector table plus scoreboard queue,
// with hand sequences for stall/flush, saturation and reset.
module tb_id_ex_imm_stage;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  rt_f;
    logic [4:0]  rd;
    logic        alu_src;
    logic        reg_dst;
    logic [3:0]  op;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        zext;
  } in_t;

  typedef struct {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic [31:0] bt;
    logic [4:0]  dst;
    logic [3:0]  op;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
    bit   bub;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_imm_ext;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic        id_alu_src;
  logic        id_reg_dst;
  logic [3:0]  id_alu_op;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_branch;
  logic        id_imm_zext;
  logic        ex_valid;
  logic [31:0] ex_alu_a;
  logic [31:0] ex_alu_b;
  logic [31:0] ex_rt_data;
  logic [31:0] ex_imm;
  logic [31:0] ex_br_target;
  logic [4:0]  ex_dst;
  logic [3:0]  ex_alu_op;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_branch;
  logic [15:0] bubble_cnt;

  int n_chk = 0;
  int n_fail = 0;
  exp_t sb[$];
  vec_t vecs[$];
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  id_ex_imm_stage #(
    .DW(32), .RW(5), .CNT_W(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_pc_plus4  (id_pc_plus4),
    .id_imm_ext   (id_imm_ext),
    .id_rs_data   (id_rs_data),
    .id_rt_data   (id_rt_data),
    .id_rt        (id_rt),
    .id_rd        (id_rd),
    .id_alu_src   (id_alu_src),
    .id_reg_dst   (id_reg_dst),
    .id_alu_op    (id_alu_op),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_mem_write (id_mem_write),
    .id_branch    (id_branch),
`ifdef IMM_ZERO_EXT_EN
    .id_imm_zext  (id_imm_zext),
`endif
    .ex_valid     (ex_valid),
    .ex_alu_a     (ex_alu_a),
    .ex_alu_b     (ex_alu_b),
    .ex_rt_data   (ex_rt_data),
    .ex_imm       (ex_imm),
    .ex_br_target (ex_br_target),
    .ex_dst       (ex_dst),
    .ex_alu_op    (ex_alu_op),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_branch    (ex_branch),
    .bubble_cnt   (bubble_cnt)
  );

  function automatic logic [15:0] sat_inc(logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  task automatic chk(string tag, string f,
                     logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s got %h expected %h",
               tag, f, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(in_t i);
    id_valid     = i.valid;
    id_pc_plus4  = i.pc;
    id_imm_ext   = i.imm;
    id_rs_data   = i.rs;
    id_rt_data   = i.rt;
    id_rt        = i.rt_f;
    id_rd        = i.rd;
    id_alu_src   = i.alu_src;
    id_reg_dst   = i.reg_dst;
    id_alu_op    = i.op;
    id_reg_write = i.rw;
    id_mem_read  = i.mr;
    id_mem_write = i.mw;
    id_branch    = i.br;
    id_imm_zext  = i.zext;
  endtask

  task automatic push(exp_t e, logic [15:0] c);
    exp_t x;
    x = e;
    x.cnt = c;
    sb.push_back(x);
  endtask

  task automatic check_out(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s.sb got empty expected entry", tag);
      return;
    end
    e = sb.pop_front();
    chk(tag, "valid", 32'(ex_valid), 32'(e.valid));
    chk(tag, "alu_a", ex_alu_a, e.a);
    chk(tag, "alu_b", ex_alu_b, e.b);
    chk(tag, "rt_data", ex_rt_data, e.rtd);
    chk(tag, "imm", ex_imm, e.imm);
    chk(tag, "br_target", ex_br_target, e.bt);
    chk(tag, "dst", 32'(ex_dst), 32'(e.dst));
    chk(tag, "alu_op", 32'(ex_alu_op), 32'(e.op));
    chk(tag, "reg_write", 32'(ex_reg_write), 32'(e.rw));
    chk(tag, "mem_read", 32'(ex_mem_read), 32'(e.mr));
    chk(tag, "mem_write", 32'(ex_mem_write), 32'(e.mw));
    chk(tag, "branch", 32'(ex_branch), 32'(e.br));
    chk(tag, "bubble_cnt", 32'(bubble_cnt), 32'(e.cnt));
  endtask

  initial begin
    exp_t z;
    z = '{default: 0};

    vecs.push_back('{
      '{1'b1, 32'h00001000, 32'h00007ABC, 32'h11111111,
        32'h22222222, 5'd3, 5'd7, 1'b1, 1'b1, 4'd2,
        1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 32'h11111111, 32'h00007ABC, 32'h22222222,
        32'h00007ABC, 32'h0001FAF0, 5'd7, 4'd2,
        1'b1, 1'b0, 1'b0, 1'b0, 16'd0},
      1'b0});
    vecs.push_back('{
      '{1'b1, 32'h00002000, 32'hFFFF8ABC, 32'hAAAA5555,
        32'h0F0F0F0F, 5'd4, 5'd9, 1'b1, 1'b0, 4'd6,
        1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 32'hAAAA5555, 32'hFFFF8ABC, 32'h0F0F0F0F,
        32'hFFFF8ABC, 32'hFFFE4AF0, 5'd4, 4'd6,
        1'b1, 1'b0, 1'b0, 1'b0, 16'd0},
      1'b0});
`ifdef IMM_ZERO_EXT_EN
    vecs.push_back('{
      '{1'b1, 32'h00002000, 32'hFFFF8ABC, 32'hAAAA5555,
        32'h0F0F0F0F, 5'd4, 5'd9, 1'b1, 1'b0, 4'd6,
        1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
      '{1'b1, 32'hAAAA5555, 32'h00008ABC, 32'h0F0F0F0F,
        32'h00008ABC, 32'h00024AF0, 5'd4, 4'd6,
        1'b1, 1'b0, 1'b0, 1'b0, 16'd0},
      1'b0});
`endif
    vecs.push_back('{
      '{1'b1, 32'h00400004, 32'hFFFFFFFF, 32'h01234567,
        32'h33333333, 5'd5, 5'd10, 1'b0, 1'b0, 4'd1,
        1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
      '{1'b1, 32'h01234567, 32'h33333333, 32'h33333333,
        32'hFFFFFFFF, 32'h00400000, 5'd5, 4'd1,
        1'b0, 1'b0, 1'b0, 1'b1, 16'd0},
      1'b0});
    vecs.push_back('{
      '{1'b1, 32'hFFFFFFFC, 32'h00000001, 32'h7FFFFFFF,
        32'h44444444, 5'd1, 5'd2, 1'b1, 1'b1, 4'd0,
        1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 32'h7FFFFFFF, 32'h00000001, 32'h44444444,
        32'h00000001, 32'h00000000, 5'd2, 4'd0,
        1'b1, 1'b1, 1'b0, 1'b0, 16'd0},
      1'b0});
    vecs.push_back('{
      '{1'b0, 32'h12345678, 32'h00000040, 32'h55555555,
        32'h66666666, 5'd11, 5'd12, 1'b1, 1'b1, 4'd3,
        1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
      z, 1'b1});
    vecs.push_back('{
      '{1'b1, 32'h00000100, 32'h00000010, 32'h00000008,
        32'hDEADBEEF, 5'd31, 5'd0, 1'b1, 1'b0, 4'd15,
        1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b1, 32'h00000008, 32'h00000010, 32'hDEADBEEF,
        32'h00000010, 32'h00000140, 5'd31, 4'd15,
        1'b0, 1'b0, 1'b1, 1'b0, 16'd0},
      1'b0});

    // reset with every input driven nonzero
    rst_n = 1'b0;
    stall = 1'b1;
    flush = 1'b1;
    apply(vecs[0].i);
    exp_cnt = 16'd0;
    repeat (2) step();
    push(z, exp_cnt);
    check_out("reset");

    rst_n = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    foreach (vecs[k]) begin
      apply(vecs[k].i);
      if (vecs[k].bub) exp_cnt = sat_inc(exp_cnt);
      push(vecs[k].e, exp_cnt);
      step();
      check_out($sformatf("vec%0d", k));
    end

    // hold A across three stalled cycles
    apply(vecs[0].i);
    push(vecs[0].e, exp_cnt);
    step();
    check_out("stall_load");
    stall = 1'b1;
    for (int j = 0; j < 3; j++) begin
      apply(vecs[j + 1].i);
      push(vecs[0].e, exp_cnt);
      step();
      check_out($sformatf("stall%0d", j));
    end

    flush = 1'b1;
    exp_cnt = sat_inc(exp_cnt);
    push(z, exp_cnt);
    step();
    check_out("stall_flush");
    stall = 1'b0;

    // drive the counter up to saturation
    repeat (16'hFFFE - exp_cnt) step();
    exp_cnt = 16'hFFFE;
    push(z, exp_cnt);
    check_out("sat_fffe");
    step();
    push(z, 16'hFFFF);
    check_out("sat_ffff");
    repeat (2) step();
    push(z, 16'hFFFF);
    check_out("sat_hold");

    flush = 1'b0;
    apply(vecs[$].i);
    push(vecs[$].e, 16'hFFFF);
    step();
    check_out("post_sat_load");

    stall = 1'b1;
    rst_n = 1'b0;
    apply(vecs[0].i);
    push(z, 16'd0);
    step();
    check_out("reset_in_stall");

    rst_n = 1'b1;
    stall = 1'b0;
    push(vecs[0].e, 16'd0);
    step();
    check_out("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
